// File: rtl/muxn_scanner_pkg.sv
// Shared types and helpers for the N-to-1 channel scanner.
package muxn_scanner_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } muxn_state_t;

    // Width of a channel index for n channels (at least one bit).
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muxn_scanner_if.sv
// Multi-channel input bus and single-channel output bus of the scanner.
interface muxn_scanner_if #(
    parameter int N = 8,
    parameter int W = 1
);
    localparam int SW = muxn_scanner_pkg::sel_width(N);

    logic [N*W-1:0] x;
    logic           mode;
    logic [SW-1:0]  sel;
    logic           en;
    logic [W-1:0]   y;
    logic [SW-1:0]  ch;
    logic           valid;
    logic           wrap;

    modport master (output x, mode, sel, en, input y, ch, valid, wrap);
    modport slave  (input x, mode, sel, en, output y, ch, valid, wrap);

endinterface

// File: rtl/muxn_scanner_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1, tick flags the terminal count.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count on enabled edges; clear restarts the dwell, terminal count rolls to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            if (clr || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/muxn_scanner.sv
// Registered N-to-1 multiplexer with manual select and automatic channel scan.
module muxn_scanner
    import muxn_scanner_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           reset,
    muxn_scanner_if.slave  bus
);
    localparam int SW = sel_width(N);
    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    muxn_state_t    state, state_nxt;
    logic [SW-1:0]  ch_nxt;
    logic           wrap_nxt;
    logic           dwell_clr;
    logic           tick;

    logic [SW-1:0]  ch_p1;
    logic [W-1:0]   y_p1;
    logic           vld_p1;
    logic           wrap_p1;

    // Channel data for index idx; indices beyond N-1 read as zero.
    function automatic logic [W-1:0] pick_chan(input logic [N*W-1:0] xv,
                                               input logic [SW-1:0]  idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SW'(k)) r = xv[k*W +: W];
        end
        return r;
    endfunction

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clr   (dwell_clr),
        .tick  (tick)
    );

    // Next state, next channel and wrap pulse; a mode change always beats a dwell expiry.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_p1;
        wrap_nxt  = 1'b0;
        dwell_clr = 1'b1;
        if (!bus.mode) begin
            state_nxt = MANUAL;
            ch_nxt    = bus.sel;
        end else if (state == MANUAL) begin
            state_nxt = SCAN;
            ch_nxt    = (ch_p1 > LAST_CH) ? '0 : ch_p1;
        end else begin
            dwell_clr = 1'b0;
            if (tick) begin
                if (ch_p1 == LAST_CH) begin
                    ch_nxt   = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    ch_nxt = ch_p1 + 1'b1;
                end
            end
        end
    end

    // ---- stage p1: registered outputs; y always carries the channel shown on ch ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MANUAL;
            ch_p1   <= '0;
            y_p1    <= '0;
            vld_p1  <= 1'b0;
            wrap_p1 <= 1'b0;
        end else if (bus.en) begin
            state   <= state_nxt;
            ch_p1   <= ch_nxt;
            y_p1    <= pick_chan(bus.x, ch_nxt);
            vld_p1  <= (ch_nxt <= LAST_CH);
            wrap_p1 <= wrap_nxt;
        end else begin
            wrap_p1 <= 1'b0;
        end
    end

    assign bus.y     = y_p1;
    assign bus.ch    = ch_p1;
    assign bus.valid = vld_p1;
    assign bus.wrap  = wrap_p1;

endmodule
